// File: rtl/result_drain.sv
// result_drain: snapshots the systolic array accumulator bus on `done` and
// streams it out one row per valid/ready transfer.
// Optional build macro: RESULT_DRAIN_RELU_EN clamps negative output elements to 0.
module result_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_SIZE = 16,
  localparam int unsigned ROW_W = $clog2(ARRAY_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       done,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH*2-1:0] result,
  input  logic                                       out_ready,
  output logic                                       out_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH*2-1:0]         out_data,
  output logic [ROW_W-1:0]                           out_row,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       overrun
);

  localparam int unsigned ElemW   = 2 * DATA_WIDTH;
  localparam int unsigned RowBits = ARRAY_SIZE * ElemW;
  localparam int unsigned BusW    = ARRAY_SIZE * RowBits;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ARRAY_SIZE - 1);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e              state_q, state_d;
  logic [BusW-1:0]     snap_q, snap_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                overrun_q, overrun_d;
  logic [RowBits-1:0]  row_sel;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: capture, row advance, back-to-back tile handoff, overrun detection
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    row_d     = row_q;
    overrun_d = overrun_q;
    case (state_q)
      StIdle: begin
        if (done) begin
          snap_d  = result;
          row_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ready && (row_q == LastRow)) begin
          // Last row leaves this edge; a coincident done starts the next tile bubble-free
          row_d = '0;
          if (done) begin
            snap_d = result;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (out_ready) begin
            row_d = row_q + ROW_W'(1);
          end
          if (done) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: purely from registered state, row mux, optional ReLU clamp
  always_comb begin
    out_valid = (state_q == StDrain);
    busy      = (state_q == StDrain);
    out_row   = row_q;
    out_last  = (state_q == StDrain) && (row_q == LastRow);
    overrun   = overrun_q;
    row_sel   = '0;
    for (int r = 0; r < int'(ARRAY_SIZE); r++) begin
      if (row_q == ROW_W'(r)) begin
        row_sel = snap_q[r*RowBits +: RowBits];
      end
    end
    out_data = row_sel;
`ifdef RESULT_DRAIN_RELU_EN
    for (int c = 0; c < int'(ARRAY_SIZE); c++) begin
      if (row_sel[c*ElemW + ElemW - 1]) begin
        out_data[c*ElemW +: ElemW] = '0;
      end
    end
`else
`endif
  end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: scoreboard of expected rows, pushed when
// a tile is issued and popped on every observed transfer.
module tb_result_drain;

  localparam int DW      = 8;
  localparam int AS      = 16;
  localparam int EW      = 2 * DW;
  localparam int ROWBITS = AS * EW;
  localparam int BUSW    = AS * ROWBITS;

  typedef struct {
    logic [3:0]         row;
    logic [ROWBITS-1:0] data;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               done;
  logic [BUSW-1:0]    result;
  logic               out_ready;
  logic               out_valid;
  logic [ROWBITS-1:0] out_data;
  logic [3:0]         out_row;
  logic               out_last;
  logic               busy;
  logic               overrun;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_xfer = 0;

  logic               stall = 1'b0;
  logic [3:0]         prev_row;
  logic [ROWBITS-1:0] prev_data;

  result_drain #(
    .DATA_WIDTH(DW),
    .ARRAY_SIZE(AS)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .result   (result),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_row  (out_row),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [ROWBITS-1:0] obs,
                           input logic [ROWBITS-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] tile_idx();
    logic [BUSW-1:0] v;
    v = '0;
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++)
        v[(r*AS+c)*EW +: EW] = 16'(r*AS + c);
    return v;
  endfunction

  function automatic logic [BUSW-1:0] tile_fill(input logic [EW-1:0] val);
    logic [BUSW-1:0] v;
    for (int i = 0; i < AS*AS; i++) v[i*EW +: EW] = val;
    return v;
  endfunction

  task automatic push_tile(input logic [BUSW-1:0] v);
    exp_t e;
    for (int r = 0; r < AS; r++) begin
      e.row  = 4'(r);
      e.data = v[r*ROWBITS +: ROWBITS];
`ifdef RESULT_DRAIN_RELU_EN
      for (int c = 0; c < AS; c++)
        if (e.data[c*EW + EW - 1]) e.data[c*EW +: EW] = '0;
`endif
      sb.push_back(e);
    end
  endtask

  // Transfer monitor: scoreboard compare plus stall-stability check
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check_val("stall_valid", ROWBITS'(out_valid), ROWBITS'(1));
        check_val("stall_row", ROWBITS'(out_row), ROWBITS'(prev_row));
        check_val("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check_val("extra_xfer", ROWBITS'(1), ROWBITS'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("row", ROWBITS'(out_row), ROWBITS'(e.row));
          check_val("data", out_data, e.data);
          check_val("last", ROWBITS'(out_last), ROWBITS'(e.row == 4'd15));
        end
      end
      stall     = out_valid && !out_ready;
      prev_row  = out_row;
      prev_data = out_data;
    end
  end

  // Issue a done pulse with tile v; checks the 1-cycle latency to out_valid
  task automatic start_tile(input logic [BUSW-1:0] v);
    @(posedge clk);
    #1;
    check_val("pre_valid", ROWBITS'(out_valid), ROWBITS'(0));
    result    = v;
    done      = 1'b1;
    out_ready = 1'b1;
    push_tile(v);
    @(posedge clk);
    #1;
    done = 1'b0;
    check_val("lat_valid", ROWBITS'(out_valid), ROWBITS'(1));
    check_val("lat_row", ROWBITS'(out_row), ROWBITS'(0));
    check_val("lat_busy", ROWBITS'(busy), ROWBITS'(1));
  endtask

  // Drive out_ready until the drain ends; optionally pulse done at a given row.
  // chk: 1 = probe row 5 col 3, 2 = probe row 0 cols 0/1 (ReLU case)
  task automatic run_drain(input bit mode, input int done_row, input logic [BUSW-1:0] nxt,
                           input bit nxt_ok, input int chk, output int cyc);
    bit fired = 1'b0;
    bit probe = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (probe) begin
        check_val("b2b_valid", ROWBITS'(out_valid), ROWBITS'(1));
        check_val("b2b_row", ROWBITS'(out_row), ROWBITS'(0));
        check_val("b2b_data", ROWBITS'(out_data[EW-1:0]), ROWBITS'(nxt[EW-1:0]));
        probe = 1'b0;
      end
      if (!out_valid) break;
      cyc++;
      if (chk == 1 && out_row == 4'd5)
        check_val("r5c3", ROWBITS'(out_data[3*EW +: EW]), ROWBITS'(16'h0053));
      if (chk == 2 && out_row == 4'd0) begin
`ifdef RESULT_DRAIN_RELU_EN
        check_val("relu_c0", ROWBITS'(out_data[EW-1:0]), ROWBITS'(16'h0000));
`else
        check_val("raw_c0", ROWBITS'(out_data[EW-1:0]), ROWBITS'(16'hFF80));
`endif
        check_val("c1", ROWBITS'(out_data[2*EW-1:EW]), ROWBITS'(16'h0123));
      end
      if (done_row >= 0 && int'(out_row) == done_row && !fired) begin
        done   = 1'b1;
        result = nxt;
        fired  = 1'b1;
        if (nxt_ok) begin
          push_tile(nxt);
          probe = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      done      = 1'b0;
      out_ready = mode ? ((cyc % 4 == 1) || (cyc % 4 == 2) ? 1'b0 : 1'b1) : 1'b1;
      if (cyc >= 200) begin
        check_val("drain_timeout", ROWBITS'(1), ROWBITS'(0));
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUSW-1:0] tile_a;
    logic [BUSW-1:0] tile_b;
    logic [BUSW-1:0] tile_c;
    int cyc;
    int k;
    int x0;

    tile_a = tile_idx();
    tile_b = tile_fill(16'h7FFF);
    tile_c = tile_a;
    tile_c[EW-1:0]    = 16'hFF80;
    tile_c[2*EW-1:EW] = 16'h0123;

    rst_n = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", ROWBITS'(out_valid), ROWBITS'(0));
    check_val("rst_busy", ROWBITS'(busy), ROWBITS'(0));
    check_val("rst_overrun", ROWBITS'(overrun), ROWBITS'(0));
    check_val("rst_row", ROWBITS'(out_row), ROWBITS'(0));
    check_val("rst_last", ROWBITS'(out_last), ROWBITS'(0));
    check_val("rst_data", out_data, ROWBITS'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: full-speed drain
    start_tile(tile_a);
    run_drain(1'b0, -1, '0, 1'b0, 1, cyc);
    check_val("t1_cycles", ROWBITS'(cyc), ROWBITS'(16));
    check_val("t1_busy", ROWBITS'(busy), ROWBITS'(0));
    check_val("t1_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));

    // 2: backpressure pattern
    x0 = n_xfer;
    start_tile(tile_a);
    run_drain(1'b1, -1, '0, 1'b0, 0, cyc);
    check_val("t2_xfers", ROWBITS'(n_xfer - x0), ROWBITS'(16));
    check_val("t2_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));
    out_ready = 1'b1;

    // 4: back-to-back tile, done coincident with last transfer
    start_tile(tile_a);
    run_drain(1'b0, 15, tile_b, 1'b1, 0, cyc);
    check_val("t4_cycles", ROWBITS'(cyc), ROWBITS'(32));
    check_val("t4_overrun", ROWBITS'(overrun), ROWBITS'(0));
    check_val("t4_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));

    // 3: done mid-drain is dropped and flagged
    start_tile(tile_a);
    run_drain(1'b0, 7, tile_b, 1'b0, 0, cyc);
    check_val("t3_cycles", ROWBITS'(cyc), ROWBITS'(16));
    check_val("t3_overrun", ROWBITS'(overrun), ROWBITS'(1));
    check_val("t3_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));
    repeat (3) begin
      @(negedge clk);
      check_val("t3_no_drain", ROWBITS'(out_valid), ROWBITS'(0));
    end
    check_val("t3_sticky", ROWBITS'(overrun), ROWBITS'(1));

    // 5: reset mid-drain
    start_tile(tile_a);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (out_row != 4'd9 && k < 50);
    check_val("t5_reach9", ROWBITS'(out_row), ROWBITS'(9));
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    check_val("t5_valid", ROWBITS'(out_valid), ROWBITS'(0));
    check_val("t5_busy", ROWBITS'(busy), ROWBITS'(0));
    check_val("t5_row", ROWBITS'(out_row), ROWBITS'(0));
    check_val("t5_data", out_data, ROWBITS'(0));
    check_val("t5_overrun", ROWBITS'(overrun), ROWBITS'(0));
    start_tile(tile_a);
    run_drain(1'b0, -1, '0, 1'b0, 1, cyc);
    check_val("t5_restart", ROWBITS'(cyc), ROWBITS'(16));
    check_val("t5_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));

    // 6: negative element, raw or ReLU depending on build
    start_tile(tile_c);
    run_drain(1'b0, -1, '0, 1'b0, 2, cyc);
    check_val("t6_cycles", ROWBITS'(cyc), ROWBITS'(16));
    check_val("t6_sb_empty", ROWBITS'(sb.size()), ROWBITS'(0));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
